// File: rtl/turn_controller.sv
// Turn sequencing for a 12-card memory game: two flips per turn, symbol compare,
// timed face-up hold on a mismatch, pair and move bookkeeping.
module turn_controller #(
    parameter int unsigned HOLD_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic        event_occurred,
    input  logic [3:0]  card_clicked_address,
    input  logic [3:0]  card_to_test_address,
    input  logic [2:0]  symbol_data,
    output logic [1:0]  card_test_state,
    output logic        checker_enable,
    output logic [3:0]  symbol_address,
    output logic [11:0] card_face_up,
    output logic [11:0] card_matched,
    output logic [2:0]  pair_count,
    output logic [7:0]  moves,
    output logic        game_over
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_FIRST,
        S_FETCH_FIRST,
        S_WAIT_SECOND,
        S_FETCH_SECOND,
        S_COMPARE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [11:0]        face_q;
    logic [11:0]        matched_q;
    logic [2:0]         pairs_q;
    logic [7:0]         moves_q;
    logic [3:0]         sym_addr_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               fetch_q;
    logic [3:0]         first_q;
    logic [3:0]         second_q;
    logic [2:0]         first_sym_q;
    logic [2:0]         second_sym_q;
    logic               game_over_q;

    logic [11:0] click_onehot;
    logic [11:0] first_onehot;
    logic [11:0] second_onehot;
    logic [15:0] blocked_vec;
    logic        wait_state;
    logic        test_valid;
    logic        click_ok;
    logic        click_ok_second;
    logic [7:0]  moves_d;
    logic [2:0]  pairs_d;
    logic [HOLD_W-1:0] hold_d;

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_decode
            assign click_onehot[gi]  = (card_clicked_address == 4'(gi + 1));
            assign first_onehot[gi]  = (first_q == 4'(gi + 1));
            assign second_onehot[gi] = (second_q == 4'(gi + 1));
        end
    endgenerate

    // Upper nibble forces out-of-range addresses (0 wraps to 15, 13..15) to read as blocked.
    assign blocked_vec = {4'hF, face_q | matched_q};

    assign wait_state      = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_SECOND);
    assign test_valid      = (card_to_test_address != 4'd0) && (card_to_test_address <= 4'd12);
    assign card_test_state = {blocked_vec[card_to_test_address - 4'd1], wait_state && test_valid};
    assign checker_enable  = wait_state && enable;

    assign click_ok        = event_occurred && (|click_onehot)
                             && ((click_onehot & (face_q | matched_q)) == 12'd0);
    assign click_ok_second = click_ok && (card_clicked_address != first_q);

    assign moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
    assign pairs_d = pairs_q + 3'd1;
    assign hold_d  = hold_q - HOLD_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_WAIT_FIRST;
            face_q       <= '0;
            matched_q    <= '0;
            pairs_q      <= '0;
            moves_q      <= '0;
            sym_addr_q   <= '0;
            hold_q       <= '0;
            fetch_q      <= 1'b0;
            first_q      <= '0;
            second_q     <= '0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            game_over_q  <= 1'b0;
        end else if (restart) begin
            state_q      <= S_WAIT_FIRST;
            face_q       <= '0;
            matched_q    <= '0;
            pairs_q      <= '0;
            moves_q      <= '0;
            sym_addr_q   <= '0;
            hold_q       <= '0;
            fetch_q      <= 1'b0;
            first_q      <= '0;
            second_q     <= '0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            game_over_q  <= 1'b0;
        end else if (enable) begin
            case (state_q)
                S_WAIT_FIRST: begin
                    if (click_ok) begin
                        face_q     <= face_q | click_onehot;
                        first_q    <= card_clicked_address;
                        sym_addr_q <= card_clicked_address;
                        fetch_q    <= 1'b0;
                        state_q    <= S_FETCH_FIRST;
                    end
                end
                S_FETCH_FIRST: begin
                    // Second cycle gives the deck ROM a full cycle after the address register.
                    if (fetch_q) begin
                        first_sym_q <= symbol_data;
                        fetch_q     <= 1'b0;
                        state_q     <= S_WAIT_SECOND;
                    end else begin
                        fetch_q <= 1'b1;
                    end
                end
                S_WAIT_SECOND: begin
                    if (click_ok_second) begin
                        face_q     <= face_q | click_onehot;
                        second_q   <= card_clicked_address;
                        sym_addr_q <= card_clicked_address;
                        fetch_q    <= 1'b0;
                        state_q    <= S_FETCH_SECOND;
                    end
                end
                S_FETCH_SECOND: begin
                    if (fetch_q) begin
                        second_sym_q <= symbol_data;
                        fetch_q      <= 1'b0;
                        state_q      <= S_COMPARE;
                    end else begin
                        fetch_q <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    moves_q <= moves_d;
                    if (first_sym_q == second_sym_q) begin
                        matched_q <= matched_q | first_onehot | second_onehot;
                        pairs_q   <= pairs_d;
                        if (pairs_d == 3'd6) begin
                            state_q     <= S_DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_FIRST;
                        end
                    end else begin
                        hold_q  <= HOLD_LOAD;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        face_q  <= face_q & ~(first_onehot | second_onehot);
                        state_q <= S_WAIT_FIRST;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                S_DONE: begin
                    game_over_q <= 1'b1;
                end
                default: begin
                    state_q <= S_WAIT_FIRST;
                end
            endcase
        end
    end

    assign symbol_address = sym_addr_q;
    assign card_face_up   = face_q;
    assign card_matched   = matched_q;
    assign pair_count     = pairs_q;
    assign moves          = moves_q;
    assign game_over      = game_over_q;

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 65_000_000, number of clk cycles a mismatched pair stays face-up.
REQ-002 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have enable  input  1  high = game running; low = freeze.
REQ-005 SHALL have restart  input  1  one-cycle pulse, starts a new game.
REQ-006 SHALL have event_occurred  input  1  one-cycle pulse, valid card click from the press checker.
REQ-007 SHALL have card_clicked_address  input  4  clicked card, 1..12, valid with event_occurred.
REQ-008 SHALL have card_to_test_address  input  4  card the press checker is currently qualifying.
REQ-009 SHALL have symbol_data  input  3  symbol of card at symbol_address, 0..5, from deck ROM.
REQ-010 SHALL have card_test_state  output  2  bit0 = selectable turn phase, bit1 = card blocked; combinational.
REQ-011 SHALL have checker_enable  output  1  enables the press checker.
REQ-012 SHALL have symbol_address  output  4  registered deck ROM address.
REQ-013 SHALL have card_face_up  output  12  bit n-1 = card n shown.
REQ-014 SHALL have card_matched  output  12  bit n-1 = card n permanently matched.
REQ-015 SHALL have pair_count  output  3  matched pairs, 0..6.
REQ-016 SHALL have moves  output  8  completed turns, saturating.
REQ-017 SHALL have game_over  output  1  high in DONE.

Function
REQ-018 SHALL implement states WAIT_FIRST, FETCH_FIRST, WAIT_SECOND, FETCH_SECOND, COMPARE, HOLD, DONE.
REQ-019 checker_enable SHALL be 1 only in WAIT_FIRST/WAIT_SECOND with enable=1.
REQ-020 card_test_state[0] SHALL be 1 iff state is WAIT_FIRST/WAIT_SECOND and card_to_test_address is in 1..12.
REQ-021 card_test_state[1] SHALL be card_face_up|card_matched at bit card_to_test_address-1 for valid address, else 1.
REQ-022 WAIT_FIRST: event_occurred with valid, non-face-up, non-matched address -> set its face-up bit, latch as first, symbol_address=address, go FETCH_FIRST.
REQ-023 FETCH_x SHALL last exactly 2 cycles; symbol_data captured on the final edge (first/second symbol); then WAIT_SECOND / COMPARE.
REQ-024 WAIT_SECOND: as REQ-022, additionally rejecting address equal to first; latch as second, go FETCH_SECOND.
REQ-025 COMPARE (1 cycle): moves+1 saturating at 255; equal symbols -> set both matched bits, pair_count+1, go DONE if new count is 6 else WAIT_FIRST; unequal -> load hold counter HOLD_CYCLES-1, go HOLD.
REQ-026 HOLD: counter decrements each cycle; at 0 clear both face-up bits, go WAIT_FIRST; total HOLD duration exactly HOLD_CYCLES cycles.
REQ-027 Matched cards SHALL keep face-up bits set.
REQ-028 DONE: game_over=1; leaves only via restart or reset.
REQ-029 Invalid/rejected addresses (0, >12, blocked, duplicate) SHALL be ignored, no state change.
REQ-030 event_occurred outside WAIT_FIRST/WAIT_SECOND SHALL be ignored.
REQ-031 enable=0 SHALL freeze state, hold counter, fetch counter and all outputs; events ignored.
REQ-032 restart SHALL have priority over all else, and acts regardless of enable: next edge yields reset values of REQ-033.

Reset
REQ-033 rst low SHALL immediately set state WAIT_FIRST, card_face_up=0, card_matched=0, pair_count=0, moves=0, symbol_address=0, hold counter=0, game_over=0; release takes effect on the next edge; assertion mid-HOLD or mid-FETCH aborts the turn.

Verification
REQ-034 Match: deck with cards 1,2 symbol 3; click 1 then 2 -> after COMPARE card_matched=0x003, pair_count=1, moves=1, back in WAIT_FIRST.
REQ-035 Mismatch: HOLD_CYCLES=10, click 1 (sym 0) then 3 (sym 1) -> face_up=0x005 for exactly 10 cycles after COMPARE, then 0x000; moves=1.
REQ-036 Rejects: click 1 then 1 again, then address 0, then 13 -> still WAIT_SECOND, face_up=0x001, card_test_state=2'b11 for addr 1.
REQ-037 Full game: 6 matching turns -> pair_count=6, game_over=1, checker_enable=0; restart pulse -> all outputs zero, WAIT_FIRST.
REQ-038 Freeze/reset: enable=0 mid-HOLD holds counter value; rst low mid-HOLD -> outputs zero immediately.
REQ-039 Saturation: 260 mismatched turns (HOLD_CYCLES=1) -> moves=255.
